// File: rtl/pmod_unit.sv
// Pmod status LEDs: per-converter WAIT/READY/ERROR indication.
// Blinking blue while waiting, dimmed green when ready, red on error.
module pmod_unit_chan #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_done,
  input  logic i_blink,
  input  logic i_pwm_on,
  output logic o_r,
  output logic o_g,
  output logic o_b
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_READY,
    ST_ERROR
  } state_t;

  localparam int TW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  state_t        w_state;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo;
  logic          r_r;
  logic          r_g;
  logic          r_b;
  logic          w_r;
  logic          w_g;
  logic          w_b;

  // synchroniser, FSM state, timeout counter and LED registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_WAIT;
      r_tmo   <= '0;
      r_r     <= 1'b0;
      r_g     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      r_s1    <= i_done;
      r_s2    <= r_s1;
      r_state <= w_state;
      r_tmo   <= w_tmo;
      r_r     <= w_r;
      r_g     <= w_g;
      r_b     <= w_b;
    end
  end

  // next state and LED colour from the current state
  always_comb begin
    w_state = r_state;
    w_tmo   = r_tmo;
    w_r     = 1'b0;
    w_g     = 1'b0;
    w_b     = 1'b0;
    unique case (r_state)
      ST_WAIT: begin
        w_b = i_blink;
        if (r_s2) begin
          w_state = ST_READY;
        end else if (TMO_EN && r_tmo == TMO_LAST) begin
          w_state = ST_ERROR;
        end else if (TMO_EN) begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      ST_READY: begin
        w_g = i_pwm_on;
        if (!r_s2) w_state = ST_ERROR;
      end
      ST_ERROR: begin
        w_r = i_pwm_on;
      end
      default: begin
        w_state = ST_WAIT;
      end
    endcase
  end

  assign o_r = r_r;
  assign o_g = r_g;
  assign o_b = r_b;

endmodule

module pmod_unit #(
  parameter int BLINK_HALF_CYCLES = 62_500_000,
  parameter int PWM_BITS          = 8,
  parameter int PWM_DUTY          = 64,
  parameter int TIMEOUT_CYCLES    = 0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_adc_init_done,
  input  logic i_dac_init_done,
  output logic o_led0_r,
  output logic o_led0_g,
  output logic o_led0_b,
  output logic o_led1_r,
  output logic o_led1_g,
  output logic o_led1_b
);

  localparam int BW =
    (BLINK_HALF_CYCLES < 2) ? 1 : $clog2(BLINK_HALF_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST =
    BW'(BLINK_HALF_CYCLES - 1);
  localparam logic [PWM_BITS:0] DUTY =
    (PWM_BITS + 1)'(PWM_DUTY);

  logic [BW-1:0]       r_blink_cnt;
  logic                r_blink_ph;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_pwm_on;

  // shared blink half-period timer and free-running PWM counter
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b1;
      r_pwm_cnt   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // extra top bit lets a duty of 2^PWM_BITS mean always on
  assign w_pwm_on = {1'b0, r_pwm_cnt} < DUTY;

  pmod_unit_chan #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_adc (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_done  (i_adc_init_done),
    .i_blink (r_blink_ph),
    .i_pwm_on(w_pwm_on),
    .o_r     (o_led0_r),
    .o_g     (o_led0_g),
    .o_b     (o_led0_b)
  );

  pmod_unit_chan #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dac (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_done  (i_dac_init_done),
    .i_blink (r_blink_ph),
    .i_pwm_on(w_pwm_on),
    .o_r     (o_led1_r),
    .o_g     (o_led1_g),
    .o_b     (o_led1_b)
  );

endmodule

// File: tb/tb_pmod_unit.sv
// Bench for pmod_unit: two configurations against a cycle model.
// Model derives blink/PWM from the edge count since reset release.
module tb_pmod_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ia;
  logic [1:0] ib;
  logic [5:0] oa;
  logic [5:0] ob;

  always #4 clk = ~clk;

  pmod_unit #(
    .BLINK_HALF_CYCLES(4),
    .PWM_BITS(2),
    .PWM_DUTY(2),
    .TIMEOUT_CYCLES(0)
  ) u_a (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_adc_init_done(ia[0]),
    .i_dac_init_done(ia[1]),
    .o_led0_r(oa[5]),
    .o_led0_g(oa[4]),
    .o_led0_b(oa[3]),
    .o_led1_r(oa[2]),
    .o_led1_g(oa[1]),
    .o_led1_b(oa[0])
  );

  pmod_unit #(
    .BLINK_HALF_CYCLES(3),
    .PWM_BITS(2),
    .PWM_DUTY(4),
    .TIMEOUT_CYCLES(100)
  ) u_b (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_adc_init_done(ib[0]),
    .i_dac_init_done(ib[1]),
    .o_led0_r(ob[5]),
    .o_led0_g(ob[4]),
    .o_led0_b(ob[3]),
    .o_led1_r(ob[2]),
    .o_led1_g(ob[1]),
    .o_led1_b(ob[0])
  );

  int BH [2] = '{4, 3};
  int PB [2] = '{2, 2};
  int DU [2] = '{2, 4};
  int TM [2] = '{0, 100};

  int passed = 0;
  int total  = 0;

  int         n;
  int         st [2][2];
  bit         h1 [2][2];
  bit         h2 [2][2];
  logic [2:0] ex [2][2];

  function automatic logic [2:0] get_o(int d, int c);
    logic [5:0] v;
    v = (d == 0) ? oa : ob;
    return (c == 0) ? v[5:3] : v[2:0];
  endfunction

  function automatic bit get_i(int d, int c);
    return (d == 0) ? ia[c] : ib[c];
  endfunction

  task automatic chk(string nm, logic [2:0] act, logic [2:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got rgb=%b expected rgb=%b at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic pin(string nm, int d, int c, logic [2:0] v);
    chk(nm, get_o(d, c), v);
  endtask

  task automatic model_reset();
    n = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        st[d][c] = 0;
        h1[d][c] = 1'b0;
        h2[d][c] = 1'b0;
        ex[d][c] = 3'b000;
      end
  endtask

  // st: 0 waiting, 1 ready, 2 error
  task automatic model_step();
    bit ph, pw, ds;
    n++;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        ph = (((n - 1) / BH[d]) % 2) == 0;
        pw = ((n - 1) % (1 << PB[d])) < DU[d];
        case (st[d][c])
          0:       ex[d][c] = {2'b00, ph};
          1:       ex[d][c] = {1'b0, pw, 1'b0};
          default: ex[d][c] = {pw, 2'b00};
        endcase
        ds = h2[d][c];
        h2[d][c] = h1[d][c];
        h1[d][c] = get_i(d, c);
        if (st[d][c] == 0) begin
          if (ds) st[d][c] = 1;
          else if (TM[d] != 0 && n == TM[d]) st[d][c] = 2;
        end else if (st[d][c] == 1 && !ds) begin
          st[d][c] = 2;
        end
      end
  endtask

  always @(posedge clk) begin
    if (rst_n === 1'b1) model_step();
    else model_reset();
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        chk($sformatf("cyc_d%0d_led%0d", d, c),
            get_o(d, c), ex[d][c]);
  end

  int e;

  task automatic adv(int k);
    repeat (k) @(posedge clk);
    e += k;
    #2;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    pin("async_rst_a0", 0, 0, 3'b000);
    pin("async_rst_a1", 0, 1, 3'b000);
    pin("async_rst_b0", 1, 0, 3'b000);
    pin("async_rst_b1", 1, 1, 3'b000);
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_run(int cycles, int odds);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, odds - 1) == 0) ia[c] = ~ia[c];
        if ($urandom_range(0, odds - 1) == 0) ib[c] = ~ib[c];
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ia = 2'b00;
    ib = 2'b00;
    e = 0;
    repeat (3) @(posedge clk);
    #2;
    pin("reset_a0", 0, 0, 3'b000);
    pin("reset_a1", 0, 1, 3'b000);
    pin("reset_b0", 1, 0, 3'b000);
    pin("reset_b1", 1, 1, 3'b000);
    @(negedge clk) rst_n = 1'b1;
    e = 0;

    adv(1);
    pin("blink_first_a0", 0, 0, 3'b001);
    pin("blink_first_b1", 1, 1, 3'b001);
    adv(3);
    pin("blink_e4_a0", 0, 0, 3'b001);
    pin("blink_e4_b1", 1, 1, 3'b000);
    adv(1);
    pin("blink_off_a0", 0, 0, 3'b000);
    adv(4);
    pin("blink_back_a1", 0, 1, 3'b001);

    adv(3);
    @(negedge clk) ia[0] = 1'b1;
    adv(4);
    pin("ready_e16_a0", 0, 0, 3'b000);
    adv(1);
    pin("ready_e17_a0", 0, 0, 3'b010);
    pin("indep_e17_a1", 0, 1, 3'b001);
    adv(1);
    pin("ready_e18_a0", 0, 0, 3'b010);
    adv(1);
    pin("ready_e19_a0", 0, 0, 3'b000);

    adv(10);
    @(negedge clk) ia[1] = 1'b1;
    adv(10);
    @(negedge clk) ia[0] = 1'b0;
    adv(6);
    pin("lost_e45_a0", 0, 0, 3'b100);
    pin("dac_green_a1", 0, 1, 3'b010);
    adv(1);
    pin("lost_e46_a0", 0, 0, 3'b100);
    adv(1);
    pin("lost_e47_a0", 0, 0, 3'b000);

    adv(13);
    @(negedge clk) ia[0] = 1'b1;
    adv(40);
    pin("tmo_e100_b0", 1, 0, 3'b000);
    pin("tmo_e100_b1", 1, 1, 3'b000);
    adv(1);
    pin("tmo_e101_b0", 1, 0, 3'b100);
    pin("tmo_e101_b1", 1, 1, 3'b100);
    pin("sticky_a0", 0, 0, 3'b100);
    @(negedge clk) ib = 2'b11;
    adv(9);
    pin("tmo_sticky_b0", 1, 0, 3'b100);

    rst_pulse();
    @(negedge clk);
    rst_n = 1'b1;
    ia = 2'b00;
    ib = 2'b11;
    e = 0;
    adv(10);
    pin("full_duty_b0", 1, 0, 3'b010);
    pin("full_duty_b1", 1, 1, 3'b010);
    pin("reblink_a0", 0, 0, 3'b001);
    rand_run(300, 20);

    rst_pulse();
    @(negedge clk);
    rst_n = 1'b1;
    ia = 2'($urandom_range(0, 3));
    ib = 2'b00;
    rand_run(300, 6);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pmod_unit.md
Name: pmod_unit

Overview:
- Status/indicator unit for the ADC and DAC Pmod interfaces.
- Watches the two init-done flags from the ADC and DAC controllers and drives two on-board RGB LEDs: LED0 shows ADC status, LED1 shows DAC status.
- Each channel runs an independent state machine: waiting (blinking blue), ready (dimmed solid green) or error (solid red).
- Sits at top level beside the converter controllers; purely observational, no handshake back.

Parameters:
- BLINK_HALF_CYCLES, 62_500_000, clock cycles per blink half-period (0.5 s at 125 MHz); minimum 1.
- PWM_BITS, 8, width of the free-running brightness PWM counter.
- PWM_DUTY, 64, on-compare for green/red brightness (on when pwm_cnt < PWM_DUTY); range 0..2^PWM_BITS.
- TIMEOUT_CYCLES, 0, cycles allowed in WAIT before ERROR; 0 disables the timeout.

Ports:
- i_clock  in  1  system clock (125 MHz, 8 ns)
- i_reset  in  1  asynchronous, active-low reset
- i_adc_init_done  in  1  ADC controller initialisation complete (asynchronous level)
- i_dac_init_done  in  1  DAC controller initialisation complete (asynchronous level)
- o_led0_r  out  1  LED0 red, active high
- o_led0_g  out  1  LED0 green, active high
- o_led0_b  out  1  LED0 blue, active high
- o_led1_r  out  1  LED1 red, active high
- o_led1_g  out  1  LED1 green, active high
- o_led1_b  out  1  LED1 blue, active high

Behaviour:
- Reset (i_reset=0, async): all six outputs 0; sync flops 0; both FSMs in WAIT; blink counter 0, blink phase 1 (on); PWM counter 0; timeout counters 0.
- Synchronisers: each init_done passes through a 2-flop synchroniser; the FSM uses stage-2 output (done_s).
- PWM: PWM_BITS counter increments every cycle and wraps; pwm_on = (pwm_cnt < PWM_DUTY). PWM_DUTY = 2^PWM_BITS gives constant on; 0 gives constant off.
- Blink: shared counter counts 0..BLINK_HALF_CYCLES-1. Blink phase toggles on the cycle the counter wraps to 0. The first toggle (to off) happens BLINK_HALF_CYCLES cycles after reset release.
- FSM per channel, states WAIT, READY, ERROR:
  - WAIT: done_s=1 -> READY. Else, if TIMEOUT_CYCLES != 0 and tmo_cnt == TIMEOUT_CYCLES-1 -> ERROR. Else tmo_cnt++.
  - If done_s and timeout coincide, READY wins.
  - READY: done_s=0 (flag lost) -> ERROR.
  - ERROR: sticky until reset; later init_done changes are ignored.
- Colour mapping (next-state of output regs):
  - WAIT: b=blink_phase, r=g=0.
  - READY: g=pwm_on, r=b=0.
  - ERROR: r=pwm_on, g=b=0.
- Outputs are registered.
- Latency: if init_done is high at rising edge k, the FSM is READY after edge k+2 and the green output is first driven after edge k+3, with blue cleared the same cycle.
- Channels are fully independent; simultaneous events on both channels are handled in parallel.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Test Plan:
- BLINK_HALF_CYCLES=4, no init: reset released -> both LEDs blue on 4 cycles, off 4 cycles, repeating; r=g=0.
- ADC done rises at 8 us (1000 cycles), PWM_BITS=2, PWM_DUTY=2 -> LED0 blue off 3 edges later, green pattern 1,1,0,0 repeating; LED1 still blinking blue.
- DAC done rises at 16 us (2000 cycles) -> LED1 switches to green identically; LED0 unaffected.
- TIMEOUT_CYCLES=100, no init -> after 100 cycles in WAIT, both LEDs red at PWM duty. Raising init_done afterwards leaves them red.
- ADC READY, then i_adc_init_done dropped -> LED0 red after 3 edges and stays red; reset pulse low -> all outputs 0 immediately, LED0 back to blinking blue.
- PWM_DUTY=2^PWM_BITS with both channels ready -> o_led0_g = o_led1_g = 1 constantly.
